// File: rtl/c64_dma_arbiter.sv
// c64_dma_arbiter
// Lets an expansion DMA master (e.g. REU) take whole C64 bus cycles. A request
// pulls the 6510 RDY low at the next cycle boundary. The 6510 ignores RDY on write
// cycles, so up to MAX_WR CPU writes are allowed to drain first. After that the
// master is granted every bus cycle the VIC-II leaves free.
//
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   phase, phi2                free-running bus-cycle phase and derived phi2
//   dma_req                    master bus request (level)
//   dma_cycle                  master may drive/sample the bus this clock
//   dma_addr/dma_dout/dma_we   master bus signals
//   dma_din                    bus read data, registered
//   cpu_addr/cpu_dout/cpu_we   CPU bus signals
//   cpu_rdy                    6510 RDY
//   vic_ba                     VIC bus-available (low: VIC owns the cycle)
//   bus_addr/bus_dout/bus_we   muxed system bus
//   bus_din                    system bus read data
//   granted                    master owns the current bus cycle
//   stolen                     saturating count of granted bus cycles
module c64_dma_arbiter #(
    parameter int unsigned PHASE_LEN = 32,
    parameter int unsigned WIN_START = 16,
    parameter int unsigned WIN_LEN   = 16,
    parameter int unsigned MAX_WR    = 3,
    localparam int unsigned PHASE_W  = $clog2(PHASE_LEN)
) (
    input  logic               clk,
    input  logic               reset,
    output logic [PHASE_W-1:0] phase,
    output logic               phi2,
    input  logic               dma_req,
    output logic               dma_cycle,
    input  logic [15:0]        dma_addr,
    input  logic [7:0]         dma_dout,
    input  logic               dma_we,
    output logic [7:0]         dma_din,
    input  logic [15:0]        cpu_addr,
    input  logic [7:0]         cpu_dout,
    input  logic               cpu_we,
    output logic               cpu_rdy,
    input  logic               vic_ba,
    output logic [15:0]        bus_addr,
    output logic [7:0]         bus_dout,
    output logic               bus_we,
    input  logic [7:0]         bus_din,
    output logic               granted,
    output logic [15:0]        stolen
);

    localparam int unsigned WR_W = $clog2(MAX_WR + 1);
    localparam logic [WR_W-1:0]    WR_MAX    = WR_W'(MAX_WR);
    localparam logic [WR_W-1:0]    WR_ONE    = WR_W'(1);
    localparam logic [PHASE_W-1:0] PHASE_ONE = PHASE_W'(1);
    // One extra bit so WIN_START+WIN_LEN == PHASE_LEN is representable.
    localparam logic [PHASE_W:0]   WIN_LO    = (PHASE_W + 1)'(WIN_START);
    localparam logic [PHASE_W:0]   WIN_HI    = (PHASE_W + 1)'(WIN_START + WIN_LEN);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HALT  = 2'd1;
    localparam logic [1:0] ST_GRANT = 2'd2;

    logic [1:0]      state;
    logic [WR_W-1:0] wr_cnt;
    logic            boundary;
    logic            in_win;
    logic [PHASE_W:0] phase_ext;

    assign boundary  = (phase == '0);
    assign phase_ext = {1'b0, phase};
    assign in_win    = (phase_ext >= WIN_LO) && (phase_ext < WIN_HI);
    // PHASE_LEN is a power of 2, so the top phase bit is exactly the upper half.
    assign phi2      = phase[PHASE_W-1];
    assign dma_cycle = granted && in_win;

    always_ff @(posedge clk) begin
        if (reset) begin
            phase   <= '0;
            state   <= ST_IDLE;
            wr_cnt  <= '0;
            cpu_rdy <= 1'b1;
            granted <= 1'b0;
            stolen  <= 16'h0000;
            dma_din <= 8'h00;
        end else begin
            phase   <= phase + PHASE_ONE;
            dma_din <= bus_din;
            if (boundary) begin
                case (state)
                    ST_IDLE: begin
                        if (dma_req) begin
                            cpu_rdy <= 1'b0;
                            wr_cnt  <= '0;
                            state   <= ST_HALT;
                        end
                    end
                    ST_HALT: begin
                        if (!dma_req) begin
                            cpu_rdy <= 1'b1;
                            state   <= ST_IDLE;
                        end else if (cpu_we && (wr_cnt < WR_MAX)) begin
                            // CPU is mid-write and cannot be halted yet.
                            wr_cnt <= wr_cnt + WR_ONE;
                        end else begin
                            state   <= ST_GRANT;
                            granted <= vic_ba;
                            if (vic_ba && (stolen != 16'hFFFF)) begin
                                stolen <= stolen + 16'd1;
                            end
                        end
                    end
                    ST_GRANT: begin
                        if (!dma_req) begin
                            granted <= 1'b0;
                            cpu_rdy <= 1'b1;
                            state   <= ST_IDLE;
                        end else begin
                            // A cycle with vic_ba low belongs to the VIC.
                            granted <= vic_ba;
                            if (vic_ba && (stolen != 16'hFFFF)) begin
                                stolen <= stolen + 16'd1;
                            end
                        end
                    end
                    default: begin
                        granted <= 1'b0;
                        cpu_rdy <= 1'b1;
                        state   <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    always_comb begin
        bus_addr = cpu_addr;
        bus_dout = cpu_dout;
        bus_we   = cpu_we;
        if (granted) begin
            bus_addr = dma_addr;
            bus_dout = dma_dout;
            bus_we   = dma_we;
        end
    end

endmodule

// File: doc/c64_dma_arbiter.md
# c64_dma_arbiter

C64-side responder for expansion DMA masters such as the REU. Accepts `dma_req`, halts the 6510 through RDY while respecting its write-cycle rule, then hands whole bus cycles to the master. In each granted cycle it asserts `dma_cycle` for a fixed window of system clocks. It sits between the CPU, the VIC-II bus-available signal and the system bus mux.

## Interface
- `PHASE_LEN`, 32: system clocks per C64 bus cycle; must be a power of 2.
- `WIN_START`, 16: phase at which the `dma_cycle` window opens.
- `WIN_LEN`, 16: `dma_cycle` window length in clocks; `WIN_START+WIN_LEN <= PHASE_LEN`.
- `MAX_WR`, 3: maximum consecutive CPU write cycles tolerated after RDY falls.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `phase`  out  $clog2(PHASE_LEN)  free-running bus-cycle phase counter.
- `phi2`  out  1  `phase >= PHASE_LEN/2`.
- `dma_req`  in  1  master requests the bus; level, held until finished.
- `dma_cycle`  out  1  master may drive and sample the bus this clock.
- `dma_addr`  in  16  master address.
- `dma_dout`  in  8  master write data.
- `dma_we`  in  1  master write strobe, already gated by the master with `dma_cycle`.
- `dma_din`  out  8  registered `bus_din`.
- `cpu_addr`  in  16  CPU address.
- `cpu_dout`  in  8  CPU write data.
- `cpu_we`  in  1  CPU write flag for the current bus cycle.
- `cpu_rdy`  out  1  6510 RDY; low halts the CPU on its next read cycle.
- `vic_ba`  in  1  VIC bus available; low means the VIC owns the cycle.
- `bus_addr`  out  16  muxed bus address.
- `bus_dout`  out  8  muxed write data.
- `bus_we`  out  1  muxed write enable.
- `bus_din`  in  8  bus read data.
- `granted`  out  1  the master owns the current bus cycle.
- `stolen`  out  16  count of granted bus cycles since reset; saturates at FFFF.

## Operation
- `phase` increments every clock and wraps from `PHASE_LEN-1` to 0. The cycle boundary is `phase==0`. All state decisions happen only on boundary clocks.
- **IDLE**: `cpu_rdy=1`, `granted=0`.
  - On a boundary with `dma_req=1`: set `cpu_rdy<=0`, set `wr_cnt<=0`, go to HALT.
- **HALT**: the CPU still owns the bus. On each boundary, in priority order:
  - `!dma_req`: set `cpu_rdy<=1`, go to IDLE. A request withdrawn before grant is legal.
  - `cpu_we=1` and `wr_cnt<MAX_WR`: `wr_cnt++`, stay in HALT. The CPU ignores RDY on writes.
  - Otherwise go to GRANT. This covers both a CPU read cycle (CPU halted) and `wr_cnt==MAX_WR`.
- **GRANT**: `granted=1` for every bus cycle in which `vic_ba` was 1 at the boundary.
  - On a boundary with `!dma_req`: set `granted<=0`, `cpu_rdy<=1`, go to IDLE.
  - A cycle with `vic_ba=0` at its boundary is lost to the VIC. `granted` is 0 for that whole cycle, there is no `dma_cycle`, and the state stays GRANT.
- `dma_cycle = granted && WIN_START <= phase < WIN_START+WIN_LEN`.
- `stolen` increments once per granted cycle, on its boundary.
- Bus mux (combinational on `granted`):
  - `granted=1`: `bus_addr=dma_addr`, `bus_dout=dma_dout`, `bus_we=dma_we`.
  - `granted=0`: `bus_addr=cpu_addr`, `bus_dout=cpu_dout`, `bus_we=cpu_we`.
- `dma_din` is registered from `bus_din` every clock.

## Timing
- Reset values: `phase=0`, `phi2=0`, state IDLE, `cpu_rdy=1`, `granted=0`, `dma_cycle=0`, `dma_din=0`, `stolen=0`, `wr_cnt=0`.
- Request to RDY low: `dma_req` rising at phase p gives `cpu_rdy` low at the next boundary, i.e. `PHASE_LEN-p` clocks later; 0..31 clocks plus 1 register clock.
- RDY low to first grant: the following boundary at minimum (one bus cycle). With 3 CPU writes, 4 bus cycles.
- Window: exactly `WIN_LEN` (16) consecutive `dma_cycle` clocks per granted cycle, at phases 16..31. A master counting 16 `dma_cycle` clocks completes one access per bus cycle.
- `dma_din` lags `bus_din` by one clock. Valid data for the window's last clock is the bus value at phase `WIN_START+WIN_LEN-2`.
- Release: after a boundary that sees `dma_req=0`, `cpu_rdy` rises and the bus returns to the CPU in the same cycle. `dma_req` dropping mid-cycle never truncates an open window.
- `vic_ba` and `cpu_we` are sampled only at the boundary; changes mid-cycle are ignored until the next boundary.
- Reset mid-grant returns to IDLE at once. `cpu_rdy=1` and the bus is returned to the CPU on the next clock.

## Test plan
- **Basic grant:** reset; `dma_req=1` at phase 5; `cpu_we=0` throughout.
  - `cpu_rdy` falls at the next boundary; `granted` at the boundary after.
  - `dma_cycle` high for phases 16..31 (16 clocks); `stolen=1`.
- **Write stall:** `dma_req=1`; `cpu_we=1` for 2 boundaries, then 0 → grant on the 3rd boundary after RDY fell.
  - With `cpu_we` stuck at 1 → grant after exactly 3 write cycles.
- **VIC steal:** in GRANT, `vic_ba=0` at one boundary → that cycle has `granted=0`, `dma_cycle=0` and `bus_addr=cpu_addr`; `stolen` does not increment. The next cycle with `vic_ba=1` is granted normally.
- **Mux/data:** `dma_addr=D020`, `dma_we` pulsed in the window → `bus_addr=D020`, `bus_we` follows.
  - `bus_din=5A` held → `dma_din=5A` one clock later.
  - With `granted=0`, `bus_addr` equals `cpu_addr`.
- **Release and abort:** `dma_req` dropped at phase 20 of a granted cycle → the window completes (16 clocks); `cpu_rdy=1` at the next boundary.
  - `dma_req` dropped in HALT → back to IDLE with no grant.
  - `reset` in GRANT → all outputs at their reset values on the next clock.
